// File: rtl/seq_detector_param.sv
// Serial pattern detector: matches a PAT_W-bit MSB-first word, with overlap and non-overlap modes.
// Optional saturating match counter when SEQ_DET_CNT_EN is defined.
module seq_detector_param #(
  parameter int              PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(4'b1011),
  parameter int              CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       inp,
  input  logic                       in_valid,
  input  logic                       ovl_en,
  input  logic                       pat_load,
  input  logic [PAT_W-1:0]           pat_in,
  output logic                       out,
  output logic [$clog2(PAT_W+1)-1:0] fill,
  output logic [CNT_W-1:0]           match_cnt
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  pattern_q;
  logic [PAT_W-1:0]  hist_q;
  logic [PAT_W-1:0]  next_hist;
  logic [FILL_W-1:0] fill_q;
  logic              out_q;
  logic              hit;

  assign next_hist = {hist_q[PAT_W-2:0], inp};

  // The fill guard keeps zero-initialised history from matching an all-zero pattern.
  assign hit = !reset && !pat_load && in_valid &&
               (next_hist == pattern_q) && (fill_q >= FILL_ARM);

  // NOTE: every register in this design uses non-blocking assignment so all
  // state updates see the pre-edge values and simulation matches hardware.
  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_q <= PATTERN;
      hist_q    <= '0;
      fill_q    <= '0;
      out_q     <= 1'b0;
    end else if (pat_load) begin
      pattern_q <= pat_in;
      hist_q    <= '0;
      fill_q    <= '0;
      out_q     <= 1'b0;
    end else if (in_valid) begin
      if (hit) begin
        out_q <= 1'b1;
        if (ovl_en) begin
          hist_q <= next_hist;
          fill_q <= FILL_FULL;
        end else begin
          // Non-overlap: discard the matched bits so none seed the next match.
          hist_q <= '0;
          fill_q <= '0;
        end
      end else begin
        out_q  <= 1'b0;
        hist_q <= next_hist;
        if (fill_q != FILL_FULL) begin
          fill_q <= fill_q + FILL_W'(1);
        end
      end
    end else begin
      out_q <= 1'b0;
    end
  end

  assign out  = out_q;
  assign fill = fill_q;

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule
